// File: rtl/wb_pkg.sv
// Shared writeback-select types and constants: source indices, default widths,
// the writeback beat layout and the skid-buffer occupancy states.
package wb_pkg;

    localparam int SRC_ALU    = 0;
    localparam int SRC_CONCAT = 1;
    localparam int SRC_MEM    = 2;
    localparam int SRC_IMM    = 3;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic [WB_DATA_W-1:0] data;
        logic [WB_ADDR_W-1:0] addr;
        logic                 we;
    } wb_beat_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Register-file write enable after the optional r0 suppression.
    function automatic logic wb_we(input logic we, input logic addr_zero, input logic r0_discard);
        return we & ~(r0_discard & addr_zero);
    endfunction

endpackage

// File: rtl/wb_select_stage_if.sv
// Source/result handshake bundle of the writeback select stage; the stage takes
// the slave side. sel_err exists only with WB_SEL_CHECK_EN.
interface wb_select_stage_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int SEL_W   = 2
);
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [SEL_W-1:0]          sel;
    logic [ADDR_W-1:0]         in_addr;
    logic                      in_we;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         out_data;
    logic [ADDR_W-1:0]         out_addr;
    logic                      out_we;
    logic                      out_valid;
    logic                      out_ready;
`ifdef WB_SEL_CHECK_EN
    logic                      sel_err;
`endif

    modport master (
        output src_data, sel, in_addr, in_we, in_valid, out_ready,
        input  in_ready, out_data, out_addr, out_we, out_valid
`ifdef WB_SEL_CHECK_EN
        , input sel_err
`endif
    );

    modport slave (
        input  src_data, sel, in_addr, in_we, in_valid, out_ready,
        output in_ready, out_data, out_addr, out_we, out_valid
`ifdef WB_SEL_CHECK_EN
        , output sel_err
`endif
    );

endinterface

// File: rtl/wb_skid_buffer.sv
// Generic 2-entry valid/ready register slice. in_ready is a flop so the
// upstream path never sees out_ready combinationally.
module wb_skid_buffer
    import wb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         rdy_q, rdy_d;
    logic         acc, cons;

    assign out_valid_o = (state_q != SKID_EMPTY);
    assign out_data_o  = out_q;
    assign in_ready_o  = rdy_q;
    assign acc         = in_valid_i & rdy_q;
    assign cons        = out_valid_o & out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (acc) begin
                    out_d   = in_data_i;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (acc && cons) begin
                    out_d = in_data_i;
                end else if (acc) begin
                    skid_d  = in_data_i;
                    state_d = SKID_FULL;
                end else if (cons) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // rdy_q is low here, so no new beat can arrive alongside the refill
                if (cons) begin
                    out_d   = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        rdy_d = (state_d != SKID_FULL);
    end

endmodule

// File: rtl/wb_select_stage.sv
// Writeback select stage: source mux + r0 write suppression feeding a skid slice.
// Optional WB_SEL_CHECK_EN drops beats with sel >= NUM_SRC and raises sticky sel_err.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int SEL_W      = 2,
    parameter int R0_DISCARD = 1
) (
    input logic              clk,
    input logic              rst,
    wb_select_stage_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              we;
    } beat_t;

    localparam int PAY_W = $bits(beat_t);

    logic [DATA_W-1:0] sel_data;
    beat_t             beat_in, beat_out;
    logic              fwd_valid;
    logic              stg_ready, stg_valid;

    // Out-of-range selects fall back to source 0.
    always_comb begin
        sel_data = bus.src_data[DATA_W-1:0];
        for (int i = 1; i < NUM_SRC; i++)
            if (int'(bus.sel) == i) sel_data = bus.src_data[i*DATA_W +: DATA_W];
    end

    always_comb begin
        beat_in.data = sel_data;
        beat_in.addr = bus.in_addr;
        beat_in.we   = wb_we(bus.in_we, bus.in_addr == '0, R0_DISCARD != 0);
    end

`ifdef WB_SEL_CHECK_EN
    logic sel_legal;
    logic sel_err_q;

    assign sel_legal = (int'(bus.sel) < NUM_SRC);
    // An illegal beat still completes the input handshake; it just never reaches the slice.
    assign fwd_valid = bus.in_valid & sel_legal;

    always_ff @(posedge clk) begin
        if (rst)
            sel_err_q <= 1'b0;
        else if (bus.in_valid && stg_ready && !sel_legal)
            sel_err_q <= 1'b1;
    end

    assign bus.sel_err = sel_err_q;
`else
    assign fwd_valid = bus.in_valid;
`endif

    wb_skid_buffer #(
        .W (PAY_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (fwd_valid),
        .in_ready_o  (stg_ready),
        .in_data_i   (beat_in),
        .out_valid_o (stg_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (beat_out)
    );

    assign bus.in_ready  = stg_ready;
    assign bus.out_valid = stg_valid;
    assign bus.out_data  = beat_out.data;
    assign bus.out_addr  = beat_out.addr;
    assign bus.out_we    = beat_out.we;

endmodule
